// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: write-back trace capture with a PC-match trigger,
// a programmable post-trigger window and oldest-first valid/ready replay.
// The block only observes the write-back stream; it never stalls the datapath.
module wb_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int POST_TRIG = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Arm,
   input  logic              TrigEn,
   input  logic [31:0]       TrigPC,
   input  logic              WB_RegWrite,
   input  logic [4:0]        WB_RegDst,
   input  logic [31:0]       WriteData,
   input  logic [31:0]       WB_PCAddResult,
   input  logic              Rd_Ready,
   output logic              Rd_Valid,
   output logic [31:0]       Rd_PC,
   output logic [4:0]        Rd_RegDst,
   output logic [31:0]       Rd_Data,
   output logic [ADDR_W:0]   Count,
   output logic [1:0]        State,
   output logic              Overflow
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_POST   = 2'd2;
   localparam logic [1:0] ST_FROZEN = 2'd3;

   localparam int ENTRY_W = 69;

   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_ZERO   = (ADDR_W+1)'(0);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] POST_LOAD  = ADDR_W'(POST_TRIG);
   localparam logic [ADDR_W-1:0] POST_ONE   = ADDR_W'(1);

   // Trace storage; contents are only observable through the valid-gated read port
   logic [ENTRY_W-1:0] mem_r [DEPTH];

   logic [1:0]        state_r,    state_s;
   logic [ADDR_W-1:0] wr_ptr_r,   wr_ptr_s;
   logic [ADDR_W-1:0] rd_ptr_r,   rd_ptr_s;
   logic [ADDR_W:0]   count_r,    count_s;
   logic [ADDR_W-1:0] post_cnt_r, post_cnt_s;
   logic              overflow_r, overflow_s;

   logic              capture_s;
   logic              full_s;
   logic              trig_s;
   logic              rd_valid_s;
   logic              pop_s;
   logic              rearm_s;
   logic [ENTRY_W-1:0] rd_entry_s;

   // Event qualification: what this cycle captures, triggers, pops or re-arms
   always_comb begin
      capture_s  = WB_RegWrite && ((state_r == ST_ARMED) || (state_r == ST_POST));
      full_s     = (count_r == FULL_COUNT);
      trig_s     = TrigEn && WB_RegWrite && (WB_PCAddResult == TrigPC);
      rd_valid_s = (state_r == ST_FROZEN) && (count_r != CNT_ZERO);
      // Arm wins over a simultaneous pop, so a pop is only taken without Arm
      pop_s      = rd_valid_s && Rd_Ready && !Arm;
      rearm_s    = Arm && ((state_r == ST_IDLE) || (state_r == ST_FROZEN));
   end

   // Next-state computation for control state, pointers, count and flags
   always_comb begin
      state_s    = state_r;
      wr_ptr_s   = wr_ptr_r;
      rd_ptr_s   = rd_ptr_r;
      count_s    = count_r;
      post_cnt_s = post_cnt_r;
      overflow_s = overflow_r;

      if (rearm_s) begin
         // Fresh capture: unread entries are discarded
         state_s    = ST_ARMED;
         wr_ptr_s   = PTR_ZERO;
         rd_ptr_s   = PTR_ZERO;
         count_s    = CNT_ZERO;
         post_cnt_s = POST_LOAD;
         overflow_s = 1'b0;
      end else begin
         if (capture_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            if (full_s) begin
               // Buffer full: drop the oldest entry to make room
               rd_ptr_s   = rd_ptr_r + PTR_ONE;
               overflow_s = 1'b1;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end else begin
            wr_ptr_s = wr_ptr_r;
         end

         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_ARMED: begin
               if (trig_s) begin
                  if (POST_TRIG == 0) begin
                     state_s = ST_FROZEN;
                  end else begin
                     state_s    = ST_POST;
                     post_cnt_s = POST_LOAD;
                  end
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_POST: begin
               // Only capture counts; further trigger matches are ignored
               if (capture_s) begin
                  post_cnt_s = post_cnt_r - POST_ONE;
                  if (post_cnt_r == POST_ONE) begin
                     state_s = ST_FROZEN;
                  end else begin
                     state_s = ST_POST;
                  end
               end else begin
                  state_s = ST_POST;
               end
            end
            ST_FROZEN: begin
               if (pop_s) begin
                  rd_ptr_s = rd_ptr_r + PTR_ONE;
                  count_s  = count_r - CNT_ONE;
                  if (count_r == CNT_ONE) begin
                     state_s = ST_IDLE;
                  end else begin
                     state_s = ST_FROZEN;
                  end
               end else begin
                  state_s = ST_FROZEN;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Control registers with asynchronous active-high reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         post_cnt_r <= PTR_ZERO;
         overflow_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         count_r    <= count_s;
         post_cnt_r <= post_cnt_s;
         overflow_r <= overflow_s;
      end
   end

   // Entry write: {PC, Dst, Data} stored at the write pointer on each captured event
   always_ff @(posedge Clk) begin
      if (capture_s) begin
         mem_r[wr_ptr_r] <= {WB_PCAddResult, WB_RegDst, WriteData};
      end
   end

   // Zero-latency read of the oldest entry, forced to zero when nothing is offered
   always_comb begin
      rd_entry_s = mem_r[rd_ptr_r];
      if (rd_valid_s) begin
         Rd_PC     = rd_entry_s[68:37];
         Rd_RegDst = rd_entry_s[36:32];
         Rd_Data   = rd_entry_s[31:0];
      end else begin
         Rd_PC     = 32'd0;
         Rd_RegDst = 5'd0;
         Rd_Data   = 32'd0;
      end
   end

   assign Rd_Valid = rd_valid_s;
   assign Count    = count_r;
   assign State    = state_r;
   assign Overflow = overflow_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: two instances (POST_TRIG=8 and POST_TRIG=0)
// share one stimulus stream; a queue-based model predicts both every cycle.
`timescale 1ns/1ps
module tb_wb_trace_buffer;

   logic        Clk = 1'b0;
   logic        Reset, Arm, TrigEn, WB_RegWrite, Rd_Ready;
   logic [31:0] TrigPC, WriteData, WB_PCAddResult;
   logic [4:0]  WB_RegDst;

   logic        a_rv, b_rv, a_ovf, b_ovf;
   logic [31:0] a_pc, b_pc, a_d, b_d;
   logic [4:0]  a_dst, b_dst, a_cnt, b_cnt;
   logic [1:0]  a_st, b_st;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .POST_TRIG(8)) dut_a (
      .Clk(Clk), .Reset(Reset), .Arm(Arm), .TrigEn(TrigEn), .TrigPC(TrigPC),
      .WB_RegWrite(WB_RegWrite), .WB_RegDst(WB_RegDst), .WriteData(WriteData),
      .WB_PCAddResult(WB_PCAddResult), .Rd_Ready(Rd_Ready), .Rd_Valid(a_rv),
      .Rd_PC(a_pc), .Rd_RegDst(a_dst), .Rd_Data(a_d), .Count(a_cnt),
      .State(a_st), .Overflow(a_ovf));

   wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .POST_TRIG(0)) dut_b (
      .Clk(Clk), .Reset(Reset), .Arm(Arm), .TrigEn(TrigEn), .TrigPC(TrigPC),
      .WB_RegWrite(WB_RegWrite), .WB_RegDst(WB_RegDst), .WriteData(WriteData),
      .WB_PCAddResult(WB_PCAddResult), .Rd_Ready(Rd_Ready), .Rd_Valid(b_rv),
      .Rd_PC(b_pc), .Rd_RegDst(b_dst), .Rd_Data(b_d), .Count(b_cnt),
      .State(b_st), .Overflow(b_ovf));

   always #5 Clk = ~Clk;

   // ---------------- behavioural model ----------------
   localparam int DEPTH = 16;
   int          pt [2] = '{8, 0};
   logic [68:0] mq [2][$];
   int          mstate [2];
   int          mpost  [2];
   bit          movf   [2];

   task automatic model_clear(input int k);
      mq[k].delete();
      mstate[k] = 0;
      mpost[k]  = 0;
      movf[k]   = 1'b0;
   endtask

   task automatic model_push(input int k, input logic [68:0] e);
      if (mq[k].size() == DEPTH) begin
         void'(mq[k].pop_front());
         movf[k] = 1'b1;
      end
      mq[k].push_back(e);
   endtask

   task automatic model_edge(input int k);
      logic [68:0] e;
      bit trig;
      e    = {WB_PCAddResult, WB_RegDst, WriteData};
      trig = TrigEn && WB_RegWrite && (WB_PCAddResult == TrigPC);
      case (mstate[k])
         0: if (Arm) begin mq[k].delete(); movf[k] = 1'b0; mstate[k] = 1; end
         1: begin
            if (WB_RegWrite) model_push(k, e);
            if (trig) begin
               if (pt[k] == 0) mstate[k] = 3;
               else begin mstate[k] = 2; mpost[k] = pt[k]; end
            end
         end
         2: if (WB_RegWrite) begin
            model_push(k, e);
            mpost[k] = mpost[k] - 1;
            if (mpost[k] == 0) mstate[k] = 3;
         end
         default: begin
            if (Arm) begin mq[k].delete(); movf[k] = 1'b0; mstate[k] = 1; end
            else if (mq[k].size() > 0 && Rd_Ready) begin
               void'(mq[k].pop_front());
               if (mq[k].size() == 0) mstate[k] = 0;
            end
         end
      endcase
   endtask

   // Model advances on the same edges as the DUT, including async reset
   always @(posedge Clk or posedge Reset) begin
      for (int k = 0; k < 2; k++) begin
         if (Reset) model_clear(k);
         else       model_edge(k);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   task automatic cmp(input int k, input logic rv, input logic [31:0] pc,
                      input logic [4:0] dst, input logic [31:0] d,
                      input logic [4:0] cnt, input logic [1:0] st, input logic ovf);
      logic        ev;
      logic [68:0] f;
      string       p;
      p  = (k == 0) ? "A" : "B";
      ev = (mstate[k] == 3) && (mq[k].size() != 0);
      f  = ev ? mq[k][0] : 69'd0;
      check({p, ".Rd_Valid"},  69'(rv),  69'(ev));
      check({p, ".Rd_PC"},     69'(pc),  69'(f[68:37]));
      check({p, ".Rd_RegDst"}, 69'(dst), 69'(f[36:32]));
      check({p, ".Rd_Data"},   69'(d),   69'(f[31:0]));
      check({p, ".Count"},     69'(cnt), 69'(mq[k].size()));
      check({p, ".State"},     69'(st),  69'(mstate[k]));
      check({p, ".Overflow"},  69'(ovf), 69'(movf[k]));
   endtask

   // Per-cycle comparison on the inactive edge
   always @(negedge Clk) begin
      if (cmp_en) begin
         cmp(0, a_rv, a_pc, a_dst, a_d, a_cnt, a_st, a_ovf);
         cmp(1, b_rv, b_pc, b_dst, b_d, b_cnt, b_st, b_ovf);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   task automatic arm();
      Arm = 1'b1;
      step();
      Arm = 1'b0;
   endtask

   task automatic wb(input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] d);
      WB_RegWrite    = 1'b1;
      WB_PCAddResult = pc;
      WB_RegDst      = dst;
      WriteData      = d;
      step();
      WB_RegWrite    = 1'b0;
   endtask

   // Assert reset away from any edge and confirm outputs clear before the next edge
   task automatic areset_check();
      #2;
      Reset = 1'b1;
      #1;
      check("areset.A.State",    69'(a_st),  69'd0);
      check("areset.A.Count",    69'(a_cnt), 69'd0);
      check("areset.A.Overflow", 69'(a_ovf), 69'd0);
      check("areset.B.Count",    69'(b_cnt), 69'd0);
      step();
      Reset = 1'b0;
   endtask

   logic [31:0] pcs [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};

   initial begin
      int hs;
      bit seen;
      Reset = 1'b1; Arm = 1'b0; TrigEn = 1'b0; TrigPC = 32'h1C;
      WB_RegWrite = 1'b0; WB_RegDst = 5'd0; WriteData = 32'd0;
      WB_PCAddResult = 32'd0; Rd_Ready = 1'b0;
      step();
      step();
      Reset = 1'b0;
      check("reset.A.State", 69'(a_st), 69'd0);
      check("reset.A.Rd_PC", 69'(a_pc), 69'd0);
      check("reset.A.Rd_Valid", 69'(a_rv), 69'd0);
      cmp_en = 1'b1;

      // 1) trigger at PC 0x1C with an 8-event post window
      TrigEn = 1'b1; TrigPC = 32'h1C;
      arm();
      for (int i = 1; i <= 5; i++) wb(32'(4 * i), 5'(i), 32'(100 + i));
      wb(32'h1C, 5'd6, 32'hCAFE);
      for (int i = 0; i < 8; i++) wb(32'h100 + 32'(4 * i), 5'(7 + i), 32'(200 + i));
      check("s1.A.State",    69'(a_st),  69'd3);
      check("s1.A.Count",    69'(a_cnt), 69'd14);
      check("s1.A.Overflow", 69'(a_ovf), 69'd0);
      check("s1.A.firstPC",  69'(a_pc),  69'h4);
      check("s1.model.size", 69'(mq[0].size()), 69'd14);
      check("s1.B.Count",    69'(b_cnt), 69'd6);
      Rd_Ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (a_st == 2'd0 && b_st == 2'd0) break;
         step();
      end
      Rd_Ready = 1'b0;
      check("s1.drain.A.State", 69'(a_st), 69'd0);

      // 2) overflow with trigger disabled, then immediate freeze (POST_TRIG=0)
      do_reset();
      TrigEn = 1'b0;
      arm();
      for (int i = 1; i <= 20; i++) wb(32'h200 + 32'(4 * i), 5'(i), 32'(i));
      TrigEn = 1'b1;
      wb(32'h1C, 5'd31, 32'hAA);
      check("s2.B.State",    69'(b_st),  69'd3);
      check("s2.B.Count",    69'(b_cnt), 69'd16);
      check("s2.B.Overflow", 69'(b_ovf), 69'd1);
      for (int i = 0; i < 16; i++) begin
         check("s2.B.readData", 69'(b_d), (i < 15) ? 69'(6 + i) : 69'hAA);
         Rd_Ready = 1'b1;
         step();
      end
      Rd_Ready = 1'b0;
      check("s2.B.endState", 69'(b_st), 69'd0);
      check("s2.A.Overflow", 69'(a_ovf), 69'd1);
      areset_check();

      // 6) async reset in POST with Count=7
      arm();
      for (int i = 0; i < 3; i++) wb(32'h40 + 32'(4 * i), 5'(i), 32'(i));
      wb(32'h1C, 5'd3, 32'h3);
      for (int i = 0; i < 3; i++) wb(32'h50 + 32'(4 * i), 5'(i), 32'(i));
      check("s6.A.State", 69'(a_st),  69'd2);
      check("s6.A.Count", 69'(a_cnt), 69'd7);
      areset_check();

      // 3) Count=3 drains in exactly three handshakes
      arm();
      wb(32'h20, 5'd1, 32'h1);
      wb(32'h24, 5'd2, 32'h2);
      wb(32'h1C, 5'd3, 32'h3);
      check("s3.B.Count", 69'(b_cnt), 69'd3);
      Rd_Ready = 1'b1;
      hs = 0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b_rv) hs++;
         step();
         if (hs == 3 && !seen) begin
            seen = 1'b1;
            check("s3.B.idleAt3", 69'(b_st), 69'd0);
         end
      end
      Rd_Ready = 1'b0;
      check("s3.handshakes", 69'(hs), 69'd3);
      check("s3.B.Rd_Valid", 69'(b_rv), 69'd0);

      // 4) Arm beats a simultaneous pop
      do_reset();
      arm();
      wb(32'h60, 5'd1, 32'h11);
      wb(32'h1C, 5'd2, 32'h22);
      Arm = 1'b1; Rd_Ready = 1'b1;
      step();
      Arm = 1'b0; Rd_Ready = 1'b0;
      check("s4.B.State", 69'(b_st),  69'd1);
      check("s4.B.Count", 69'(b_cnt), 69'd0);
      wb(32'h70, 5'd3, 32'h33);
      wb(32'h1C, 5'd4, 32'h44);
      check("s4.B.Rd_PC", 69'(b_pc), 69'h70);

      // 5) PC match without RegWrite neither triggers nor captures
      arm();
      wb(32'h80, 5'd5, 32'h55);
      WB_RegWrite = 1'b0; WB_PCAddResult = 32'h1C;
      step();
      check("s5.B.State", 69'(b_st),  69'd1);
      check("s5.B.Count", 69'(b_cnt), 69'd1);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         Arm            = ($urandom_range(39) == 0);
         TrigEn         = ($urandom_range(3) != 0);
         WB_RegWrite    = ($urandom_range(2) != 0);
         WB_PCAddResult = ($urandom_range(7) == 0) ? 32'h1C : pcs[$urandom_range(2)];
         WB_RegDst      = 5'($urandom);
         WriteData      = $urandom;
         Rd_Ready       = $urandom_range(1) == 1;
         step();
      end
      Arm = 1'b0; WB_RegWrite = 1'b0; Rd_Ready = 1'b0;
      step();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
